// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and defaults for the two-port instruction memory arbiter
package imem_arb_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_WAIT = 2'd1,
        PORT_HOLD = 2'd2
    } port_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/imem_arb_port.sv
// rtl/imem_arb_port.sv - one port's response FSM, hold register and eligibility
module imem_arb_port
    import imem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rready,
    input  logic        gnt,
    input  logic        err,
    input  logic [31:0] mem_rdata,
    output logic        eligible,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        rerr
);

    port_state_t state_q, state_d;
    logic        err_q;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_err_q, hold_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PORT_IDLE;
            err_q       <= 1'b0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_err_q  <= hold_err_d;
            if (gnt) begin
                err_q <= err;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_err_d  = hold_err_q;
        rvalid      = 1'b0;
        rdata       = '0;
        rerr        = 1'b0;
        case (state_q)
            PORT_IDLE: begin
                if (gnt) state_d = PORT_WAIT;
            end
            PORT_WAIT: begin
                // Memory data is only valid this cycle, so bypass it straight out.
                rvalid = 1'b1;
                rdata  = err_q ? 32'h0 : mem_rdata;
                rerr   = err_q;
                if (rready) begin
                    state_d = gnt ? PORT_WAIT : PORT_IDLE;
                end else begin
                    state_d     = PORT_HOLD;
                    hold_data_d = err_q ? 32'h0 : mem_rdata;
                    hold_err_d  = err_q;
                end
            end
            PORT_HOLD: begin
                rvalid = 1'b1;
                rdata  = hold_data_q;
                rerr   = hold_err_q;
                if (rready) begin
                    state_d     = gnt ? PORT_WAIT : PORT_IDLE;
                    hold_data_d = '0;
                    hold_err_d  = 1'b0;
                end
            end
            default: state_d = PORT_IDLE;
        endcase
        if (rst) begin
            rvalid = 1'b0;
            rdata  = '0;
            rerr   = 1'b0;
        end
    end

    assign eligible = req && ((state_q == PORT_IDLE) || (rvalid && rready));

endmodule

// File: rtl/imem_arb.sv
// rtl/imem_arb.sv - round-robin two-port read arbiter for a single-port sync-read instruction memory
// Optional misaligned-address error responses: IMEM_ARB_ALIGN_CHK_EN
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [31:0]       p0_addr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_rerr,
    input  logic              p0_rready,
    input  logic              p1_req,
    input  logic [31:0]       p1_addr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_rerr,
    input  logic              p1_rready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    logic      rst_q;
    logic      block;
    port_idx_t last_q;
    logic      elig0, elig1;
    logic      mis0, mis1;
    logic      rd0, rd1;

`ifdef IMEM_ARB_ALIGN_CHK_EN
    assign mis0 = (p0_addr[1:0] != 2'b00);
    assign mis1 = (p1_addr[1:0] != 2'b00);
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[31:ADDR_W+2], p1_addr[31:ADDR_W+2]};
`else
    assign mis0 = 1'b0;
    assign mis1 = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[31:ADDR_W+2], p0_addr[1:0],
                                p1_addr[31:ADDR_W+2], p1_addr[1:0]};
`endif

    // Grants stay off for one extra cycle after reset so every output reads 0 then.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q  <= 1'b1;
            last_q <= PORT1;
        end else begin
            rst_q <= 1'b0;
            if (p0_gnt) begin
                last_q <= PORT0;
            end else if (p1_gnt) begin
                last_q <= PORT1;
            end
        end
    end

    assign block  = rst || rst_q;
    assign p0_gnt = !block && elig0 && (!elig1 || (last_q == PORT1));
    assign p1_gnt = !block && elig1 && (!elig0 || (last_q == PORT0));

    assign rd0      = p0_gnt && !mis0;
    assign rd1      = p1_gnt && !mis1;
    assign mem_en   = rd0 || rd1;
    assign mem_addr = rd0 ? p0_addr[ADDR_W+1:2] :
                      rd1 ? p1_addr[ADDR_W+1:2] : '0;

    imem_arb_port u_port0 (
        .clk       (clk),
        .rst       (rst),
        .req       (p0_req),
        .rready    (p0_rready),
        .gnt       (p0_gnt),
        .err       (mis0),
        .mem_rdata (mem_rdata),
        .eligible  (elig0),
        .rvalid    (p0_rvalid),
        .rdata     (p0_rdata),
        .rerr      (p0_rerr)
    );

    imem_arb_port u_port1 (
        .clk       (clk),
        .rst       (rst),
        .req       (p1_req),
        .rready    (p1_rready),
        .gnt       (p1_gnt),
        .err       (mis1),
        .mem_rdata (mem_rdata),
        .eligible  (elig1),
        .rvalid    (p1_rvalid),
        .rdata     (p1_rdata),
        .rerr      (p1_rerr)
    );

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL be the memory word-address width (4096 words).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 p0_req  in  1  SHALL be the port-0 read request, level, held until granted.
REQ-005 p0_addr  in  32  SHALL be the port-0 byte address.
REQ-006 p0_gnt  out  1  SHALL indicate the port-0 request is accepted this cycle.
REQ-007 p0_rvalid  out  1  SHALL flag valid port-0 response data.
REQ-008 p0_rdata  out  32  SHALL carry the port-0 instruction word.
REQ-009 p0_rerr  out  1  SHALL flag a misaligned port-0 request, qualified by p0_rvalid.
REQ-010 p0_rready  in  1  SHALL indicate port 0 consumes its response this cycle.
REQ-011 p1_req, p1_addr, p1_gnt, p1_rvalid, p1_rdata, p1_rerr, p1_rready SHALL mirror REQ-004..010 for port 1.
REQ-012 mem_en  out  1  SHALL strobe a read to the single-port synchronous-read memory.
REQ-013 mem_addr  out  ADDR_W  SHALL be the word index, granted address bits [ADDR_W+1:2].
REQ-014 mem_rdata  in  32  SHALL be the memory data, valid exactly one cycle after mem_en.

Function
REQ-015 A port SHALL be eligible when req=1 and it holds no response, or its response is consumed this cycle (rvalid&&rready).
REQ-016 At most one grant per cycle; gnt SHALL be combinational from req/rready/arbitration state.
REQ-017 Single eligible port SHALL be granted; both eligible SHALL grant the port not granted most recently (round-robin); last-granted pointer SHALL reset to port 1 so port 0 wins first.
REQ-018 mem_en SHALL equal OR of grants; mem_addr SHALL be 0 when mem_en=0.
REQ-019 Per-port response FSM: IDLE -> WAIT on grant; WAIT (cycle N+1) drives rvalid=1, rdata=mem_rdata bypass; WAIT with rready=1 -> IDLE, or WAIT again if re-granted.
REQ-020 WAIT with rready=0 SHALL capture mem_rdata into a hold register and go HOLD; HOLD drives rvalid=1, rdata=hold, stable until rready=1, then IDLE (or WAIT if re-granted same cycle).
REQ-021 Latency SHALL be one cycle grant-to-rvalid; sustained throughput one read per cycle total, one per cycle per port when alone.
REQ-022 rdata/rerr SHALL be 0 whenever rvalid=0.
REQ-023 req dropped without grant SHALL have no effect; req while HOLD with rready=0 SHALL be ignored.

Reset
REQ-024 rst SHALL force both FSMs IDLE, clear hold registers, set pointer to port 1; all outputs 0 in the reset cycle and the cycle after.
REQ-025 rst mid-transaction SHALL drop any in-flight or held response without emitting rvalid.

Configuration
REQ-026 With IMEM_ARB_ALIGN_CHK_EN defined, a granted request with addr[1:0]!=0 SHALL NOT assert mem_en; next cycle rvalid=1, rerr=1, rdata=0, same FSM/hold rules.
REQ-027 Without IMEM_ARB_ALIGN_CHK_EN, addr[1:0] SHALL be ignored and rerr tied 0.

Structure
REQ-028 Package imem_arb_pkg SHALL hold ADDR_W default, port FSM state enum (IDLE/WAIT/HOLD) and port-index typedef.
REQ-029 Sub-module imem_arb_port SHALL implement one port's FSM, hold register and eligibility, instantiated twice.

Verification
REQ-030 p0_req, addr 0x10, rready=1 -> cycle 0 gnt, mem_addr=4; cycle 1 p0_rvalid, rdata=mem[4].
REQ-031 Both req continuously, rready=1 -> grants p0,p1,p0,p1; mem_addr alternates per p0/p1 addresses.
REQ-032 p1 granted addr 0x20, p1_rready=0 for 3 cycles -> rdata=mem[8] stable 4 cycles, p1_gnt=0 until rready, p0 still served.
REQ-033 rst asserted in WAIT cycle -> p*_rvalid stays 0, next request granted with p0 priority.
REQ-034 With IMEM_ARB_ALIGN_CHK_EN, p0_addr 0x6 -> mem_en=0, next cycle rvalid=1, rerr=1, rdata=0; without macro -> mem_addr=1, rerr=0.
